// File: rtl/ps2_rx_framer_pkg.sv
// Shared PS/2 framing definitions: FSM states, frame layout and parity helper.
// Also intended for use by the host-to-device transmitter.
package ps2_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam int PS2_DATA_BITS          = 8;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  // Bit positions within an 11-bit device-to-host frame.
  localparam int FRAME_START_POS    = 0;
  localparam int FRAME_DATA_LSB_POS = 1;
  localparam int FRAME_PARITY_POS   = 9;
  localparam int FRAME_STOP_POS     = 10;
  localparam int FRAME_BITS         = 11;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_framer_glitch_filter.sv
// Two-flop synchronizer followed by a run-length debounce for one PS/2 pin.
// Outputs the filtered level and a one-cycle pulse on its 1->0 transition.
module ps2_rx_framer_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] run_q, run_d;

  // NOTE: every variable gets a default before any branch, so no latch can be inferred.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    run_d   = '0;
    if (sync_q[1] != level_q) begin
      if (run_q == RUN_LAST) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      fall_q  <= fall_d;
      run_q   <= run_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: filters the pins, frames start/data/parity/stop
// and emits one strobe per good byte, or a single error pulse per bad frame.
module ps2_rx_framer
  import ps2_rx_framer_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       global_clk,
  input  logic       global_rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       inhibit,
  output logic       ps2_clk_drive_low,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int            BW      = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);
  localparam int            HW      = $clog2(FILTER_LEN + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(FILTER_LEN);

  state_e                     state_q, state_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
  logic                       parity_q, parity_d;
  logic [TW-1:0]              to_cnt_q, to_cnt_d;
  logic [HW-1:0]              hold_q, hold_d;
  logic [7:0]                 key_code_q, key_code_d;
  logic                       strobe_q, strobe_d;
  logic                       perr_q, perr_d;
  logic                       ferr_q, ferr_d;
  logic                       drive_low_q;
  logic [1:0]                 data_sync_q;

  logic clk_level;
  logic clk_fall;
  logic data_s;
  logic bit_event;

  ps2_rx_framer_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (global_clk),
    .rst_n   (global_rst_n),
    .raw_i   (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  assign data_s = data_sync_q[1];

  // The holdoff lets the filter settle on the released line before edges count again.
  assign bit_event = clk_fall & ~clk_level & ~inhibit & (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (inhibit) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    to_cnt_d   = to_cnt_q;
    key_code_d = key_code_q;
    strobe_d   = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (inhibit) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else if (bit_event) begin
      to_cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d[bit_cnt_q] = data_s;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // A bad stop bit outranks a parity failure.
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, parity_q)) begin
            key_code_d = shift_q;
            strobe_d   = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      state_d  = ST_IDLE;
      ferr_d   = 1'b1;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge global_clk) begin
    if (!global_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      hold_q      <= '0;
      key_code_q  <= 8'h00;
      strobe_q    <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      drive_low_q <= 1'b0;
      data_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      hold_q      <= hold_d;
      key_code_q  <= key_code_d;
      strobe_q    <= strobe_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      drive_low_q <= inhibit;
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign ps2_clk_drive_low = drive_low_q;
  assign key_code          = key_code_q;
  assign key_strobe        = strobe_q;
  assign parity_error      = perr_q;
  assign frame_error       = ferr_q;

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Randomized bench for ps2_rx_framer: a PS/2 device model drives frames while
// a monitor matches every output pulse against an expectation queue.
module tb_ps2_rx_framer;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HP         = 30;   // PS/2 clock half period in system cycles

  typedef enum int {EV_NONE = 0, EV_KEY = 1, EV_PERR = 2, EV_FERR = 3} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] code;
  } exp_t;

  logic       global_clk   = 1'b0;
  logic       global_rst_n = 1'b0;
  logic       dev_clk      = 1'b1;
  logic       ps2_data_in  = 1'b1;
  logic       inhibit      = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_clk_drive_low;
  logic [7:0] key_code;
  logic       key_strobe;
  logic       parity_error;
  logic       frame_error;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_pulse_cyc = 0;
  logic rst_seen = 1'b0;
  logic [7:0] model_code = 8'h00;
  logic prev_pulse = 1'b0;
  exp_t exp_q[$];

  // Open-drain line: the host pulls low while inhibiting.
  assign ps2_clk_in = dev_clk & ~ps2_clk_drive_low;

  ps2_rx_framer #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .global_clk        (global_clk),
    .global_rst_n      (global_rst_n),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_data_in       (ps2_data_in),
    .inhibit           (inhibit),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .key_code          (key_code),
    .key_strobe        (key_strobe),
    .parity_error      (parity_error),
    .frame_error       (frame_error)
  );

  always #5 global_clk = ~global_clk;

  always @(posedge global_clk) begin
    cyc      <= cyc + 1;
    rst_seen <= global_rst_n;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Pulse monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge global_clk) begin
    int  npulse;
    ev_e obs;
    exp_t e;
    if (!rst_seen) begin
      model_code = 8'h00;
      prev_pulse = 1'b0;
    end else begin
      npulse = int'(key_strobe) + int'(parity_error) + int'(frame_error);
      if (npulse != 0) begin
        check("one_pulse_per_cycle", npulse, 1);
        check("pulse_not_stretched", int'(prev_pulse), 0);
        obs = key_strobe ? EV_KEY : (parity_error ? EV_PERR : EV_FERR);
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_pulse", int'(obs), int'(EV_NONE));
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(obs), int'(e.kind));
          if (e.kind == EV_KEY) model_code = e.code;
        end
      end
      check("key_code", int'(key_code), int'(model_code));
      prev_pulse = (npulse != 0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge global_clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input logic glitch, output int fall_cyc);
    ps2_data_in = v;
    if (glitch) begin
      wait_cycles(10);
      dev_clk = 1'b0;
      wait_cycles(3);
      dev_clk = 1'b1;
      wait_cycles(HP - 13);
    end else begin
      wait_cycles(HP);
    end
    dev_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cycles(HP);
    dev_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch, output int stop_fall);
    logic par;
    logic stop;
    int   f;
    exp_t e;
    par  = ~(^b) ^ bad_par;
    stop = ~bad_stop;
    e.code = b;
    if (!stop)                                   e.kind = EV_FERR;
    else if ((($countones(b) + int'(par)) % 2) == 1) e.kind = EV_KEY;
    else                                         e.kind = EV_PERR;
    exp_q.push_back(e);
    drive_bit(1'b0, glitch, f);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch, f);
    drive_bit(par, glitch, f);
    drive_bit(stop, glitch, stop_fall);
    ps2_data_in = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_code"},  int'(key_code), 0);
    check({tag, "_strobe"},    int'(key_strobe), 0);
    check({tag, "_perr"},      int'(parity_error), 0);
    check({tag, "_ferr"},      int'(frame_error), 0);
    check({tag, "_drive_low"}, int'(ps2_clk_drive_low), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   f;
    int   stop_f;
    exp_t e;
    logic [7:0] rb;
    int   r;

    // Reset state.
    wait_cycles(5);
    @(negedge global_clk);
    check_reset_outputs("reset");
    @(posedge global_clk); #1;
    global_rst_n = 1'b1;
    wait_cycles(40);

    // Single good frame, with pin-to-strobe latency.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, stop_f);
    drain("drain_1c", 200);
    check("strobe_latency", last_pulse_cyc - stop_f, FILTER_LEN + 3);
    check("code_1c", int'(key_code), 'h1C);

    // Back-to-back frames.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, stop_f);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, stop_f);
    drain("drain_f0_1c", 200);

    // Bad parity keeps the previous code.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, stop_f);
    drain("drain_bad_parity", 200);
    check("code_after_perr", int'(key_code), 'h1C);

    // Bad stop bit, then a good frame with clock glitches.
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, stop_f);
    drain("drain_bad_stop", 200);
    wait_cycles(2 * HP);
    send_frame(8'h29, 1'b0, 1'b0, 1'b1, stop_f);
    drain("drain_glitch_29", 200);
    check("code_29", int'(key_code), 'h29);

    // Timeout after 4 data bits.
    wait_cycles(2 * HP);
    e.kind = EV_FERR;
    e.code = 8'h00;
    exp_q.push_back(e);
    drive_bit(1'b0, 1'b0, f);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, f);
    ps2_data_in = 1'b1;
    drain("drain_timeout", TIMEOUT + 200);
    check("timeout_latency", last_pulse_cyc - f, TIMEOUT + FILTER_LEN + 3);
    wait_cycles(2 * HP);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, stop_f);
    drain("drain_12", 200);

    // Inhibit mid-frame: silent abort, then a good frame.
    wait_cycles(2 * HP);
    drive_bit(1'b0, 1'b0, f);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0, f);
    ps2_data_in = 1'b1;
    inhibit = 1'b1;
    @(negedge global_clk);
    check("drive_low_not_yet", int'(ps2_clk_drive_low), 0);
    @(negedge global_clk);
    check("drive_low_next_cycle", int'(ps2_clk_drive_low), 1);
    wait_cycles(100);
    check("drive_low_held", int'(ps2_clk_drive_low), 1);
    inhibit = 1'b0;
    wait_cycles(1);
    check("drive_low_released", int'(ps2_clk_drive_low), 0);
    wait_cycles(60);
    check("no_pulse_from_inhibit", exp_q.size(), 0);
    send_frame(8'h76, 1'b0, 1'b0, 1'b0, stop_f);
    drain("drain_76", 200);
    check("code_76", int'(key_code), 'h76);

    // Reset mid-frame.
    wait_cycles(2 * HP);
    drive_bit(1'b0, 1'b0, f);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, f);
    global_rst_n = 1'b0;
    wait_cycles(3);
    @(negedge global_clk);
    check_reset_outputs("midframe_reset");
    @(posedge global_clk); #1;
    global_rst_n = 1'b1;
    ps2_data_in  = 1'b1;
    wait_cycles(100);
    check("code_after_reset", int'(key_code), 0);

    // Randomized frames with parity/stop faults, glitches and variable gaps.
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      r  = int'($urandom_range(0, 99));
      send_frame(rb, r < 20, (r >= 20) && (r < 35), $urandom_range(0, 3) == 0, stop_f);
      wait_cycles(int'($urandom_range(0, 2)) * HP);
    end
    drain("drain_random", 200);
    wait_cycles(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
